// File: rtl/biquad8_pkg.sv
// rtl/biquad8_pkg.sv - shared constants and FSM state type for the biquad8 pole coefficient loader
// Optional frame-synchronised update: BIQUAD8_COEFF_SYNC_EN adds the WAIT_SYNC state.
package biquad8_pkg;

  localparam int NCOEFF          = 4;
  localparam int COEFF_BITS      = 18;
  localparam int COEFF_FRAC_BITS = 14;
  localparam int CNT_BITS        = $clog2(NCOEFF);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(NCOEFF - 1);

  localparam int SYNC_TIMEOUT  = 1023;
  localparam int SYNC_CNT_BITS = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_UPDATE
`ifdef BIQUAD8_COEFF_SYNC_EN
    , ST_WAIT_SYNC
`endif
  } state_e;

endpackage

// File: rtl/biquad8_pole_coeff_loader.sv
// rtl/biquad8_pole_coeff_loader.sv - shadow/snapshot coefficient loader driving the pole IIR B-cascade
// Build option BIQUAD8_COEFF_SYNC_EN holds the final update until sync_i or a timeout.
module biquad8_pole_coeff_loader
  import biquad8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cfg_addr_i,
  input  logic [COEFF_BITS-1:0] cfg_dat_i,
  input  logic                  cfg_wr_i,
  input  logic                  cfg_commit_i,
  input  logic                  sync_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pending_o,
  output logic [COEFF_BITS-1:0] coeff_dat_o,
  output logic                  coeff_wr_o,
  output logic                  coeff_update_o
);

  logic [COEFF_BITS-1:0] shadow_q [NCOEFF];
  logic [COEFF_BITS-1:0] snap_q   [NCOEFF];
  state_e                state_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic                  pending_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wr_q;
  logic                  upd_q;
  logic [COEFF_BITS-1:0] dat_q;
  logic                  shadow_we_d;

  assign shadow_we_d = cfg_wr_i && (32'(cfg_addr_i) < NCOEFF);

`ifdef BIQUAD8_COEFF_SYNC_EN
  logic [SYNC_CNT_BITS-1:0] sync_cnt_q;
`else
  logic unused_sync;
  assign unused_sync = sync_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEFF; i++) shadow_q[i] <= '0;
    end else if (shadow_we_d) begin
      shadow_q[cfg_addr_i] <= cfg_dat_i;
    end
  end

  // dat_q always carries the word for the cycle after the edge, so cnt_q
  // names the DSP whose coefficient is currently on coeff_dat_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEFF; i++) snap_q[i] <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      upd_q     <= 1'b0;
      dat_q     <= '0;
`ifdef BIQUAD8_COEFF_SYNC_EN
      sync_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      upd_q  <= 1'b0;
      wr_q   <= 1'b0;
      dat_q  <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_commit_i || pending_q) begin
            snap_q    <= shadow_q;
            cnt_q     <= CNT_LAST;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            wr_q      <= 1'b1;
            dat_q     <= shadow_q[CNT_LAST];
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cfg_commit_i) pending_q <= 1'b1;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            wr_q  <= 1'b1;
            dat_q <= snap_q[cnt_q - 1'b1];
          end else begin
`ifdef BIQUAD8_COEFF_SYNC_EN
            sync_cnt_q <= '0;
            state_q    <= ST_WAIT_SYNC;
`else
            upd_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_UPDATE;
`endif
          end
        end
`ifdef BIQUAD8_COEFF_SYNC_EN
        ST_WAIT_SYNC: begin
          if (cfg_commit_i) pending_q <= 1'b1;
          if (sync_i || (sync_cnt_q == SYNC_CNT_BITS'(SYNC_TIMEOUT - 1))) begin
            upd_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_UPDATE;
          end else begin
            sync_cnt_q <= sync_cnt_q + 1'b1;
          end
        end
`endif
        ST_UPDATE: begin
          // A commit seen in this cycle only queues; the next state follows the old flag.
          pending_q <= cfg_commit_i;
          if (pending_q) begin
            snap_q  <= shadow_q;
            cnt_q   <= CNT_LAST;
            wr_q    <= 1'b1;
            dat_q   <= shadow_q[CNT_LAST];
            state_q <= ST_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pending_o      = pending_q;
  assign coeff_dat_o    = dat_q;
  assign coeff_wr_o     = wr_q;
  assign coeff_update_o = upd_q;

endmodule

// File: tb/tb_biquad8_pole_coeff_loader.sv
// tb/tb_biquad8_pole_coeff_loader.sv - directed self-checking bench for the biquad8 pole coefficient loader
// Sync-hold scenarios are compiled in only with BIQUAD8_COEFF_SYNC_EN.
module tb_biquad8_pole_coeff_loader;
  import biquad8_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [1:0]            cfg_addr_i = '0;
  logic [COEFF_BITS-1:0] cfg_dat_i = '0;
  logic                  cfg_wr_i = 1'b0;
  logic                  cfg_commit_i = 1'b0;
  logic                  sync_i = 1'b0;
  logic                  busy_o, done_o, pending_o, coeff_wr_o, coeff_update_o;
  logic [COEFF_BITS-1:0] coeff_dat_o;

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  int n_upd = 0;
  int n_wr = 0;

  always #5 clk = ~clk;

  biquad8_pole_coeff_loader dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_dat_i     (cfg_dat_i),
    .cfg_wr_i      (cfg_wr_i),
    .cfg_commit_i  (cfg_commit_i),
    .sync_i        (sync_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pending_o     (pending_o),
    .coeff_dat_o   (coeff_dat_o),
    .coeff_wr_o    (coeff_wr_o),
    .coeff_update_o(coeff_update_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (done_o) n_done++;
    if (coeff_update_o) n_upd++;
    if (coeff_wr_o) n_wr++;
  endtask

  task automatic write_shadow(input logic [1:0] a, input logic [COEFF_BITS-1:0] d);
    cfg_addr_i = a;
    cfg_dat_i  = d;
    cfg_wr_i   = 1'b1;
    tick();
    cfg_wr_i   = 1'b0;
  endtask

  task automatic load_shadow(input logic [COEFF_BITS-1:0] d0, d1, d2, d3);
    write_shadow(2'd0, d0);
    write_shadow(2'd1, d1);
    write_shadow(2'd2, d2);
    write_shadow(2'd3, d3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_o); end
    tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b want 0", pending_o); end
    tests++; if (coeff_wr_o !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b want 0", coeff_wr_o); end
    tests++; if (coeff_update_o !== 1'b0) begin fails++; $display("FAIL reset_update: got %b want 0", coeff_update_o); end
    tests++; if (coeff_dat_o !== '0) begin fails++; $display("FAIL reset_dat: got %h want 0", coeff_dat_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    logic [COEFF_BITS-1:0] w [4];
    logic [COEFF_BITS-1:0] exp_dat;
    logic exp_wr;
    w[0] = 18'h00011; w[1] = 18'h00022; w[2] = 18'h00033; w[3] = 18'h00044;
    load_shadow(w[0], w[1], w[2], w[3]);
    cfg_commit_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      cfg_commit_i = 1'b0;
      exp_wr  = (c >= 1 && c <= 4);
      exp_dat = exp_wr ? w[4-c] : '0;
      tests++; if (coeff_wr_o !== exp_wr) begin fails++; $display("FAIL basic_wr c%0d: got %b want %b", c, coeff_wr_o, exp_wr); end
      tests++; if (coeff_dat_o !== exp_dat) begin fails++; $display("FAIL basic_dat c%0d: got %h want %h", c, coeff_dat_o, exp_dat); end
      tests++; if (coeff_update_o !== (c == 5)) begin fails++; $display("FAIL basic_update c%0d: got %b want %b", c, coeff_update_o, c == 5); end
      tests++; if (done_o !== (c == 5)) begin fails++; $display("FAIL basic_done c%0d: got %b want %b", c, done_o, c == 5); end
      tests++; if (busy_o !== (c >= 1 && c <= 5)) begin fails++; $display("FAIL basic_busy c%0d: got %b want %b", c, busy_o, c >= 1 && c <= 5); end
    end
  endtask

  task automatic test_pending();
    int d0;
    d0 = n_done;
    cfg_commit_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      cfg_commit_i = 1'b0;
      cfg_wr_i = 1'b0;
      if (c == 3) begin
        tests++; if (pending_o !== 1'b1) begin fails++; $display("FAIL pend_flag: got %b want 1", pending_o); end
      end
      if (c == 6) begin
        tests++; if (coeff_wr_o !== 1'b1 || pending_o !== 1'b0) begin fails++; $display("FAIL pend_restart: got wr=%b pend=%b want wr=1 pend=0", coeff_wr_o, pending_o); end
      end
      if (c == 9) begin
        tests++; if (coeff_wr_o !== 1'b1 || coeff_dat_o !== 18'h3FFFF) begin fails++; $display("FAIL pend_last_word: got wr=%b dat=%h want wr=1 dat=3ffff", coeff_wr_o, coeff_dat_o); end
      end
      if (c == 10) begin
        tests++; if (coeff_update_o !== 1'b1) begin fails++; $display("FAIL pend_update2: got %b want 1", coeff_update_o); end
      end
      if (c == 11) begin
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL pend_idle: got busy=%b want 0", busy_o); end
      end
      if (c == 1) begin
        cfg_addr_i = 2'd0; cfg_dat_i = 18'h3FFFF; cfg_wr_i = 1'b1;
      end
      if (c == 2) cfg_commit_i = 1'b1;
    end
    tests++; if (n_done - d0 !== 2) begin fails++; $display("FAIL pend_done_count: got %0d want 2", n_done - d0); end
  endtask

  task automatic test_merge();
    int d0, w0;
    d0 = n_done;
    w0 = n_wr;
    cfg_commit_i = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      cfg_commit_i = (c >= 1 && c <= 3);
      if (c == 12) begin
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL merge_pending: got %b want 0", pending_o); end
      end
    end
    tests++; if (n_done - d0 !== 2) begin fails++; $display("FAIL merge_done_count: got %0d want 2", n_done - d0); end
    tests++; if (n_wr - w0 !== 8) begin fails++; $display("FAIL merge_wr_count: got %0d want 8", n_wr - w0); end
  endtask

  task automatic test_reset_mid();
    int u0;
    cfg_commit_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      cfg_commit_i = 1'b0;
    end
    u0 = n_upd;
    rst = 1'b1;
    #1;
    tests++; if (coeff_wr_o !== 1'b0 || busy_o !== 1'b0 || coeff_dat_o !== '0) begin fails++; $display("FAIL rstmid_async: got wr=%b busy=%b dat=%h want 0", coeff_wr_o, busy_o, coeff_dat_o); end
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    tests++; if (n_upd - u0 !== 0) begin fails++; $display("FAIL rstmid_no_update: got %0d updates want 0", n_upd - u0); end
    load_shadow(18'h00101, 18'h00202, 18'h00303, 18'h00404);
    cfg_commit_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      cfg_commit_i = 1'b0;
      if (c == 1) begin
        tests++; if (coeff_dat_o !== 18'h00404) begin fails++; $display("FAIL rstmid_first: got %h want 00404", coeff_dat_o); end
      end
      if (c == 4) begin
        tests++; if (coeff_dat_o !== 18'h00101) begin fails++; $display("FAIL rstmid_last: got %h want 00101", coeff_dat_o); end
      end
      if (c == 5) begin
        tests++; if (coeff_update_o !== 1'b1) begin fails++; $display("FAIL rstmid_update: got %b want 1", coeff_update_o); end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_same_cycle_write();
    load_shadow(18'h00011, 18'h00022, 18'h00033, 18'h00044);
    cfg_commit_i = 1'b1;
    cfg_addr_i = 2'd1; cfg_dat_i = 18'h12345; cfg_wr_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      cfg_commit_i = 1'b0;
      cfg_wr_i = 1'b0;
      if (c == 3) begin
        tests++; if (coeff_dat_o !== 18'h00022) begin fails++; $display("FAIL samecyc_old: got %h want 00022", coeff_dat_o); end
      end
    end
    cfg_commit_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      cfg_commit_i = 1'b0;
      if (c == 3) begin
        tests++; if (coeff_dat_o !== 18'h12345) begin fails++; $display("FAIL samecyc_new: got %h want 12345", coeff_dat_o); end
      end
    end
  endtask

`ifdef BIQUAD8_COEFF_SYNC_EN
  task automatic test_sync();
    int first;
    cfg_commit_i = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      cfg_commit_i = 1'b0;
      tests++; if (coeff_update_o !== (c == 15)) begin fails++; $display("FAIL sync_update c%0d: got %b want %b", c, coeff_update_o, c == 15); end
      sync_i = (c == 14);
    end
    sync_i = 1'b0;
    first = 0;
    cfg_commit_i = 1'b1;
    for (int c = 1; c <= 1035; c++) begin
      tick();
      cfg_commit_i = 1'b0;
      if (coeff_update_o && first == 0) first = c;
    end
    tests++; if (first !== 5 + SYNC_TIMEOUT) begin fails++; $display("FAIL sync_timeout: got cycle %0d want %0d", first, 5 + SYNC_TIMEOUT); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef BIQUAD8_COEFF_SYNC_EN
    test_sync();
`else
    test_basic_load();
    test_pending();
    test_merge();
    test_reset_mid();
    test_same_cycle_write();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/biquad8_pole_coeff_loader.md
Name: biquad8_pole_coeff_loader

Overview:
- Sequences coefficient loads into the 4-DSP pole IIR chain of the biquad8 filter.
- Host writes four 18-bit pole coefficients into a shadow buffer and issues a commit.
- The FSM shifts the snapshot down the B-cascade (coeff_wr), then fires one coeff_update so all four DSPs switch to the new set in the same cycle.
- Sits between the register-bus slave and the pole IIR, in the IIR clock domain.

Parameters:
- NCOEFF, 4, number of DSPs in the cascade, which is also the number of coefficients.
- COEFF_BITS, 18, coefficient width; format Q4.14 signed.
- SYNC_TIMEOUT, 1023, max cycles to wait for sync_i before forcing the update (feature only).

Ports:
- clk  in  1  single clock, IIR domain.
- rst  in  1  asynchronous, active-high reset.
- cfg_addr_i  in  2  shadow index; value k = coefficient for DSPk.
- cfg_dat_i  in  COEFF_BITS  shadow write data.
- cfg_wr_i  in  1  write cfg_dat_i to shadow[cfg_addr_i].
- cfg_commit_i  in  1  request a load of the current shadow contents.
- sync_i  in  1  frame-alignment strobe; used only with the feature.
- busy_o  out  1  a load sequence is in progress.
- done_o  out  1  one-cycle pulse, same cycle coeff_update_o is high.
- pending_o  out  1  a commit is queued behind the active load.
- coeff_dat_o  out  COEFF_BITS  to IIR coeff_dat_i.
- coeff_wr_o  out  1  to IIR coeff_wr_i (cascade shift enable).
- coeff_update_o  out  1  to IIR coeff_update_i (B2 latch).

Behaviour:
- Reset:
  - All outputs 0; shadow and snapshot registers all-zero.
  - FSM goes to IDLE; pending flag cleared.
  - Reset mid-sequence aborts with no coeff_update. The IIR keeps its old B2 coefficients; partially shifted B1 values are overwritten by the next load.
- Shadow:
  - cfg_wr_i writes take effect at the next edge, in any state.
  - A write in the same cycle as an accepted commit is NOT in that snapshot; it lands in the next one.
- FSM states: IDLE, SHIFT, UPDATE (plus WAIT_SYNC with the feature).
- IDLE:
  - On cfg_commit_i (or a pending commit), copy shadow to snapshot, load cnt = NCOEFF-1, clear pending, go to SHIFT.
  - busy_o rises on the next cycle.
- SHIFT:
  - Each cycle: coeff_wr_o=1, coeff_dat_o=snapshot[cnt], cnt decrements.
  - Order is DSP3, DSP2, DSP1, DSP0, because the first word in travels furthest.
  - Exactly NCOEFF contiguous cycles; at cnt==0 go to UPDATE.
- UPDATE:
  - One cycle with coeff_update_o=1, done_o=1, coeff_wr_o=0, busy_o=1.
  - Next state: SHIFT if a commit is pending (snapshot retaken), else IDLE.
- Timing: commit sampled at edge 0 gives coeff_wr_o in cycles 1..4, coeff_update_o in cycle 5, busy_o in cycles 1..5.
- coeff_wr_o and coeff_update_o are never high in the same cycle.
- coeff_dat_o is 0 whenever coeff_wr_o=0.
- All outputs are registered; no combinational paths from inputs to outputs.
- Commit while busy sets pending (one deep). Extra commits while pending=1 are merged; pending_o reflects the flag.
- A commit in the UPDATE cycle itself also sets pending.
- cfg_addr_i values >= NCOEFF are ignored (no write).

Optional Feature:
- Macro BIQUAD8_COEFF_SYNC_EN.
- Defined:
  - After SHIFT, enter WAIT_SYNC and hold with no wr/update.
  - On sync_i=1 go to UPDATE next cycle. A sync_i already high on WAIT_SYNC entry counts.
  - A counter forces UPDATE after SYNC_TIMEOUT cycles without sync_i.
  - busy_o stays high throughout WAIT_SYNC.
- Undefined: sync_i is ignored, the WAIT_SYNC state is not built, and SHIFT goes directly to UPDATE.

Decomposition:
- Package biquad8_pkg holds:
  - the state enum;
  - the constants NCOEFF=4 and COEFF_BITS=18;
  - the coefficient-format localparam COEFF_FRAC_BITS=14;
  - the sync timeout counter width.
- No sub-module needed: the shadow and snapshot are small register arrays and the FSM is flat.
- Top-level integration instantiates this loader plus biquad8_pole_iir, wired port to port.

Test Plan:
- Write shadow 0..3 = 0x00011, 0x00022, 0x00033, 0x00044, then commit → coeff_wr_o cycles 1-4 carry 0x00044, 0x00033, 0x00022, 0x00011; coeff_update_o and done_o in cycle 5; busy_o in cycles 1-5.
- Commit in cycle 2 of an active load after rewriting shadow[0]=0x3FFFF → pending_o=1; second SHIFT starts the cycle after UPDATE, with last word 0x3FFFF; two done_o pulses total.
- Three commits during one load → exactly two load sequences.
- Assert rst in cycle 3 of SHIFT → all outputs 0 asynchronously; coeff_update_o never asserted; a fresh commit then completes normally.
- cfg_wr_i coincident with accepted commit (addr 1, 0x12345) → current load uses the old shadow[1]; next commit sends 0x12345 in third wr cycle.
- BIQUAD8_COEFF_SYNC_EN defined, sync_i pulsed 10 cycles after SHIFT ends → update exactly 1 cycle after sync_i. With no sync_i → update after SYNC_TIMEOUT cycles.
